// File: rtl/msx_slot_master.sv
// MSX cartridge-slot bus master: turns single request/response transactions into
// timed mreq_n/sltsl_n/rd_n/wr_n cycles. It also caches the secondary-slot register at FFFF.
module msx_slot_master #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    input  logic [3:0]  page_match,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_dout_oe,
    input  logic [7:0]  bus_din,
    output logic        mreq_n,
    output logic        sltsl_n,
    output logic        rd_n,
    output logic        wr_n,
    input  logic        wait_n,
    output logic [7:0]  ssl_shadow,
    output logic        ssl_err,
    input  logic        ssl_err_clr
);

    localparam int unsigned CW       = 8;
    localparam logic [15:0] SSL_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITST, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic          done_c;
    logic          abort_c;
    logic          ssl_hit_c;

    // Bus-cycle completion: normal end of strobe/wait, or wait timeout.
    always_comb begin
        done_c    = 1'b0;
        abort_c   = 1'b0;
        ssl_hit_c = (bus_addr == SSL_ADDR);
        if (state == STROBE && cnt == CW'(T_STROBE - 1) && wait_n) begin
            done_c = 1'b1;
        end
        if (state == WAITST) begin
            if (wait_n) begin
                done_c = 1'b1;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                abort_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_q        <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b0;
            bus_addr    <= 16'h0000;
            bus_dout    <= 8'h00;
            bus_dout_oe <= 1'b0;
            mreq_n      <= 1'b1;
            sltsl_n     <= 1'b1;
            rd_n        <= 1'b1;
            wr_n        <= 1'b1;
            ssl_shadow  <= 8'h00;
            ssl_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (ssl_err_clr) begin
                ssl_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        bus_addr  <= req_addr;
                        wr_q      <= req_wr;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        if (req_wr) begin
                            bus_dout <= req_wdata;
                        end
                        if (page_match[req_addr[15:14]]) begin
                            state       <= SETUP;
                            mreq_n      <= 1'b0;
                            sltsl_n     <= 1'b0;
                            bus_dout_oe <= req_wr;
                        end else begin
                            state       <= HOLD;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= 8'hFF;
                            rsp_timeout <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == CW'(T_SETUP - 1)) begin
                        state <= STROBE;
                        cnt   <= '0;
                        rd_n  <= wr_q;
                        wr_n  <= !wr_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STROBE: begin
                    if (cnt == CW'(T_STROBE - 1)) begin
                        state <= WAITST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAITST: begin
                    cnt <= cnt + CW'(1);
                end
                HOLD: begin
                    state       <= IDLE;
                    req_ready   <= 1'b1;
                    bus_dout_oe <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Leaving the strobe phase overrides the per-state updates above.
            if (done_c || abort_c) begin
                state       <= HOLD;
                cnt         <= '0;
                mreq_n      <= 1'b1;
                sltsl_n     <= 1'b1;
                rd_n        <= 1'b1;
                wr_n        <= 1'b1;
                rsp_valid   <= 1'b1;
                rsp_timeout <= abort_c;
                rsp_rdata   <= abort_c ? 8'hFF : bus_din;
                if (done_c && ssl_hit_c) begin
                    if (wr_q) begin
                        ssl_shadow <= bus_dout;
                    end else if (bus_din != ~ssl_shadow) begin
                        ssl_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_msx_slot_master.sv
// Randomized bench for msx_slot_master against a transaction-level model of
// latency, strobe widths, response data and the secondary-slot shadow/error state.
module tb_msx_slot_master;

    localparam int TS = 2;
    localparam int TST = 4;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [3:0]  page_match;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, bus_din;
    logic        bus_dout_oe;
    logic        mreq_n, sltsl_n, rd_n, wr_n, wait_n;
    logic [7:0]  ssl_shadow;
    logic        ssl_err, ssl_err_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_shadow = 8'h00;
    logic       m_err = 1'b0;

    msx_slot_master #(.T_SETUP(TS), .T_STROBE(TST), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .page_match(page_match),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_dout_oe(bus_dout_oe), .bus_din(bus_din),
        .mreq_n(mreq_n), .sltsl_n(sltsl_n), .rd_n(rd_n), .wr_n(wr_n), .wait_n(wait_n),
        .ssl_shadow(ssl_shadow), .ssl_err(ssl_err), .ssl_err_clr(ssl_err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One transaction; wait_n is held low for wl cycles starting at the last strobe cycle.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [3:0] pm, input int wl, input logic [7:0] din,
                           input logic clr);
        bit   matched, to, got, set_err;
        int   waits, lat, lat_got, first_st, rd_lo, wr_lo, mreq_lo, oe_hi, viol;
        logic [7:0] exp_rd;
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
        page_match = pm; bus_din = din; wait_n = 1'b1; ssl_err_clr = clr;
        matched = pm[addr[15:14]];
        waits   = (!matched || wl == 0) ? 0 : (wl > TO ? TO : wl);
        to      = matched && (wl > TO);
        lat     = matched ? TS + TST + waits + 1 : 1;
        exp_rd  = (!matched || to) ? 8'hFF : din;
        set_err = 1'b0;
        if (matched && !to && addr == 16'hFFFF) begin
            if (wr) m_shadow = wd;
            else set_err = (din != ~m_shadow);
        end
        m_err = set_err | (m_err & !clr);
        got = 0; lat_got = 0; first_st = 0; rd_lo = 0; wr_lo = 0; mreq_lo = 0; oe_hi = 0; viol = 0;
        @(posedge clk);
        for (int k = 1; k <= 400 && !got; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            page_match = 4'($urandom);
            wait_n     = !(matched && k >= TS + TST && k < TS + TST + wl);
            if (!rd_n) rd_lo++;
            if (!wr_n) wr_lo++;
            if ((!rd_n || !wr_n) && first_st == 0) first_st = k;
            if (!mreq_n) mreq_lo++;
            if (bus_dout_oe) oe_hi++;
            if ((!rd_n && !wr_n) || (mreq_n != sltsl_n) || (wr && !rd_n) || (!wr && !wr_n)) viol++;
            if (rsp_valid) begin
                got = 1; lat_got = k;
                check("rsp_rdata", rsp_rdata, exp_rd);
                check("rsp_timeout", rsp_timeout, to);
                check("hold_addr", bus_addr, addr);
                check("hold_strobes", {mreq_n, sltsl_n, rd_n, wr_n}, 4'hF);
                check("ssl_shadow", ssl_shadow, m_shadow);
                check("ssl_err", ssl_err, m_err);
                if (wr && matched) check("hold_dout", bus_dout, wd);
            end
        end
        if (!got) check("rsp_wait_expired", 0, 1);
        check("latency", lat_got, lat);
        check("first_strobe", first_st, matched ? TS + 1 : 0);
        check("rd_low", rd_lo, (matched && !wr) ? TST + waits : 0);
        check("wr_low", wr_lo, (matched && wr) ? TST + waits : 0);
        check("mreq_low", mreq_lo, matched ? TS + TST + waits : 0);
        check("oe_high", oe_hi, (matched && wr) ? TS + TST + waits + 1 : 0);
        check("strobe_rules", viol, 0);
        ssl_err_clr = 1'b0;
        @(negedge clk);
        check("ready_after", {req_ready, rsp_valid}, 2'b10);
        check("rdata_held", {rsp_timeout, rsp_rdata}, {to, exp_rd});
    endtask

    task automatic clear_err;
        @(negedge clk);
        ssl_err_clr = 1'b1;
        @(negedge clk);
        ssl_err_clr = 1'b0;
        m_err = 1'b0;
        check("err_cleared", ssl_err, 0);
    endtask

    // Write to FFFF interrupted by reset during its strobe phase.
    task automatic reset_mid_write;
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'hFFFF; req_wdata = 8'h99;
        page_match = 4'b1000; wait_n = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= TS + 2; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("pre_rst_wr", wr_n, 0);
        reset = 1'b1;
        #1;
        check("rst_async_strobes", {mreq_n, sltsl_n, rd_n, wr_n, bus_dout_oe}, 5'b11110);
        @(negedge clk);
        reset = 1'b0;
        m_shadow = 8'h00; m_err = 1'b0;
        seen = 0;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_regs", {ssl_shadow, ssl_err, rsp_rdata, rsp_timeout}, 18'h0);
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid) seen = 1;
            @(negedge clk);
        end
        check("rst_no_rsp", seen, 0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
        page_match = 4'h0; bus_din = 8'h0; wait_n = 1'b1; ssl_err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobes", {mreq_n, sltsl_n, rd_n, wr_n, bus_dout_oe, rsp_valid}, 6'b111100);
        check("rst_data", {bus_addr, bus_dout, rsp_rdata, rsp_timeout}, 33'h0);
        check("rst_ssl", {ssl_shadow, ssl_err, req_ready}, 10'b0000000001);
        reset = 1'b0;

        run_txn(1'b1, 16'hFFFF, 8'hA5, 4'b1000, 0, 8'h00, 1'b0);
        run_txn(1'b0, 16'hFFFF, 8'h00, 4'b1000, 0, 8'h5A, 1'b0);
        run_txn(1'b0, 16'hFFFF, 8'h00, 4'b1000, 0, 8'h5B, 1'b0);
        clear_err();
        run_txn(1'b0, 16'h4000, 8'h00, 4'b0000, 0, 8'h77, 1'b0);
        run_txn(1'b0, 16'h8000, 8'h00, 4'b0100, 10, 8'h3C, 1'b0);
        run_txn(1'b1, 16'hFFFF, 8'hC3, 4'b1000, 300, 8'h00, 1'b0);
        run_txn(1'b0, 16'hFFFF, 8'h00, 4'b1000, TO, 8'h12, 1'b0);
        run_txn(1'b0, 16'hFFFF, 8'h00, 4'b1000, TO + 1, 8'h13, 1'b0);
        run_txn(1'b0, 16'hFFFF, 8'h00, 4'b1000, 3, 8'h11, 1'b1);
        run_txn(1'b1, 16'h2345, 8'h6E, 4'b0001, 1, 8'h00, 1'b0);
        reset_mid_write();

        for (int i = 0; i < 40; i++) begin
            logic        r_wr;
            logic [15:0] r_addr;
            logic [7:0]  r_din;
            int          r_wl;
            r_wr   = 1'($urandom);
            r_addr = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
            r_wl   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            r_din  = ($urandom_range(0, 1) == 0) ? ~m_shadow : 8'($urandom);
            run_txn(r_wr, r_addr, 8'($urandom), 4'($urandom), r_wl, r_din,
                    1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msx_slot_master.md
MSX_SLOT_MASTER -- requirements
Module: msx_slot_master

Interface
REQ-001 Parameters SHALL be T_SETUP, default 2, clk cycles of address/sltsl_n setup before strobe (min 1).
REQ-002 Parameters SHALL include T_STROBE, default 4, minimum rd_n/wr_n low cycles (min 1).
REQ-003 Parameters SHALL include TIMEOUT, default 255, maximum wait_n-low cycles before abort (8-bit counter).
REQ-004 Ports: clk  in  1  single clock; all logic rises on posedge clk.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: req_valid in 1, req_ready out 1, req_wr in 1, req_addr in 16, req_wdata in 8  request channel.
REQ-007 Ports: rsp_valid out 1, rsp_rdata out 8, rsp_timeout out 1  response, one-cycle pulse.
REQ-008 Ports: page_match in 4  bit n=1 means page n (addr[15:14]=n) is mapped to this slot.
REQ-009 Ports: bus_addr out 16, bus_dout out 8, bus_dout_oe out 1, bus_din in 8  cartridge address/data.
REQ-010 Ports: mreq_n, sltsl_n, rd_n, wr_n  out 1 each, active-low strobes; wait_n  in 1  cartridge wait.
REQ-011 Ports: ssl_shadow out 8  cached secondary slot register; ssl_err out 1 sticky; ssl_err_clr in 1.

Function
REQ-012 FSM SHALL have states IDLE, SETUP, STROBE, WAITST, HOLD.
REQ-013 req_ready SHALL be 1 exactly when state is IDLE; a request is accepted on req_valid & req_ready.
REQ-014 On accept, addr/wr/wdata SHALL be latched; bus_addr SHALL show the latched address from the next cycle until IDLE.
REQ-015 Accepted request whose page_match[req_addr[15:14]]=0 SHALL go directly to HOLD with no strobe activity, rsp_rdata=8'hFF, rsp_timeout=0.
REQ-016 Matched request SHALL enter SETUP for T_SETUP cycles with mreq_n=0, sltsl_n=0, rd_n=wr_n=1.
REQ-017 STROBE SHALL last T_STROBE cycles with mreq_n=0, sltsl_n=0 and rd_n=0 (read) or wr_n=0 (write), never both.
REQ-018 Writes SHALL drive bus_dout=latched wdata and bus_dout_oe=1 from SETUP through HOLD inclusive; reads SHALL hold bus_dout_oe=0.
REQ-019 In the last STROBE cycle, wait_n=0 SHALL move to WAITST, else to HOLD.
REQ-020 WAITST SHALL keep strobes asserted, count wait_n-low cycles, exit to HOLD on first cycle wait_n=1.
REQ-021 WAITST count reaching TIMEOUT SHALL abort to HOLD with rsp_timeout=1, rsp_rdata=8'hFF.
REQ-022 Read data SHALL be registered from bus_din on the clock edge that leaves STROBE/WAITST to HOLD (non-timeout).
REQ-023 HOLD SHALL last 1 cycle: mreq_n, sltsl_n, rd_n, wr_n all 1, bus_addr held, rsp_valid=1; then IDLE.
REQ-024 Latency, matched, no wait: accept at cycle N -> rsp_valid at N+T_SETUP+T_STROBE+1, next accept at N+T_SETUP+T_STROBE+2.
REQ-025 Latency, unmatched: accept at N -> rsp_valid at N+1.
REQ-026 Completed (non-timeout) matched write to 16'hFFFF SHALL load ssl_shadow with wdata on HOLD entry.
REQ-027 Completed matched read of 16'hFFFF SHALL set ssl_err when bus_din != ~ssl_shadow; rsp_rdata still = bus_din.
REQ-028 Timed-out accesses to 16'hFFFF SHALL change neither ssl_shadow nor ssl_err.
REQ-029 ssl_err_clr=1 SHALL clear ssl_err next edge; simultaneous set and clear SHALL leave ssl_err=1.
REQ-030 page_match changes after accept SHALL not affect the cycle in progress (sampled at accept only).
REQ-031 rsp_rdata and rsp_timeout SHALL hold their values until the next HOLD.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, mreq_n=sltsl_n=rd_n=wr_n=1, bus_dout_oe=0.
REQ-033 Reset values SHALL be bus_addr=0, bus_dout=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, ssl_shadow=0, ssl_err=0, counters 0.
REQ-034 Reset mid-cycle SHALL drop the request with no rsp_valid; req_ready=1 from the first cycle after release.

Verification
REQ-035 page_match=4'b1000, write FFFF<=8'hA5, wait_n=1 -> wr_n low cycles N+3..N+6, rsp_valid at N+7, ssl_shadow=8'hA5.
REQ-036 Then read FFFF with bus_din=8'h5A -> rsp_rdata=8'h5A, ssl_err=0; repeat with bus_din=8'h5B -> ssl_err=1, clears after ssl_err_clr.
REQ-037 page_match=4'b0000, read 16'h4000 -> no strobe toggles, rsp_valid at N+1, rsp_rdata=8'hFF.
REQ-038 Read 16'h8000 (page 2 matched), wait_n low 10 cycles then high, bus_din=8'h3C -> rd_n low 14 cycles, rsp_rdata=8'h3C, rsp_timeout=0.
REQ-039 Write FFFF with wait_n held low -> rsp_timeout=1 after 255 WAITST cycles, rsp_rdata=8'hFF, ssl_shadow unchanged.
REQ-040 reset pulsed during STROBE of a write -> wr_n, mreq_n, sltsl_n =1 immediately, no rsp_valid, ssl_shadow=0, req_ready=1 after release.
